// File: rtl/nibble_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nibble_deserializer_pkg
// Purpose : Shared definitions for the nibble deserializer: FSM state
//           encodings and the counter-width helper function.
// Revision: 1.0 - initial release
// ============================================================================
package nibble_deserializer_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    // Number of bits needed to hold the value itself (i.e. $clog2(value+1)),
    // never less than 1 so a counter for value 0 still has a legal width.
    function automatic int unsigned nd_bits_for(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((w < 32'd32) && ((64'd1 << w) <= 64'(value)))
            w = w + 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/deser_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module  : deser_timeout_ctr
// Purpose : Counts idle cycles inside a frame and flags expiry.
// Ports   : clk     - clock
//           rst_n   - asynchronous active-low reset
//           clr     - clear the count (has priority over inc)
//           inc     - one more idle cycle this clock
//           expired - this idle cycle is the TIMEOUT-th one (0 if TIMEOUT==0)
// Revision: 1.0 - initial release
// ============================================================================
module deser_timeout_ctr
    import nibble_deserializer_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = ^{clk, rst_n, clr, inc};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam int unsigned c_cnt_w = nd_bits_for(TIMEOUT);
            localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);
            localparam logic [c_cnt_w-1:0] c_max  = c_cnt_w'(TIMEOUT);

            logic [c_cnt_w-1:0] r_count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (clr) begin
                    r_count <= '0;
                end else if (inc && (r_count != c_max)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Combinational so the FSM can abort on the very edge that
            // samples the TIMEOUT-th idle cycle.
            assign expired = inc && (r_count >= c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/nibble_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : nibble_deserializer
// Purpose : Collects a framed serial bit stream into a WIDTH-bit word and
//           presents it with a valid/ready handshake. Flags resync, timeout
//           and overrun framing errors as registered one-cycle pulses.
// Ports   : clk, rst_n                        - clock, async active-low reset
//           ser_valid, ser_data, frame_start  - serial input
//           out_valid, out_ready, out_bits    - parallel output handshake
//           err_resync, err_timeout, err_overrun - error pulses
// Revision: 1.0 - initial release
// ============================================================================
module nibble_deserializer
    import nibble_deserializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_valid,
    input  logic             ser_data,
    input  logic             frame_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits,
    output logic             err_resync,
    output logic             err_timeout,
    output logic             err_overrun
);

    localparam int unsigned        c_cnt_w    = nd_bits_for(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    // A one-bit frame is complete as soon as its first bit lands.
    localparam logic [1:0] c_first_state = (WIDTH == 1) ? c_st_full : c_st_shift;

    logic [1:0]         r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_shreg, w_shifted;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic               w_load;
    logic               r_err_resync, r_err_timeout, r_err_overrun;
    logic               w_resync_nxt, w_timeout_nxt, w_overrun_nxt;
    logic               w_tmo_clr, w_tmo_inc, w_tmo_expired;

    // Insertion order. Leftover bits from an aborted frame are simply shifted
    // out by the next WIDTH insertions, so the first bit needs no special load.
    generate
        if (WIDTH == 1) begin : g_single
            assign w_shifted = ser_data;
        end else if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shreg[WIDTH-2:0], ser_data};
        end else begin : g_lsb_first
            assign w_shifted = {ser_data, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    assign w_cnt_inc = r_cnt + 1'b1;

    // Idle cycles only count while a partial frame is open.
    assign w_tmo_inc = (r_state == c_st_shift) && !ser_valid;
    assign w_tmo_clr = (r_state != c_st_shift) || ser_valid;

    deser_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_tmo_clr),
        .inc     (w_tmo_inc),
        .expired (w_tmo_expired)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_load        = 1'b0;
        w_resync_nxt  = 1'b0;
        w_timeout_nxt = 1'b0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                // Unframed bits are dropped silently here.
                if (ser_valid && frame_start) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = c_cnt_one;
                    w_state_nxt = c_first_state;
                end
            end
            c_st_shift: begin
                if (ser_valid) begin
                    w_load = 1'b1;
                    if (frame_start) begin
                        w_cnt_nxt    = c_cnt_one;
                        w_resync_nxt = 1'b1;
                        w_state_nxt  = c_first_state;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_cnt_full) begin
                            w_state_nxt = c_st_full;
                        end
                    end
                end else if (w_tmo_expired) begin
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = c_st_idle;
                end
            end
            c_st_full: begin
                if (out_ready) begin
                    // Same-cycle transfer and new frame start: no bubble.
                    if (ser_valid && frame_start) begin
                        w_load      = 1'b1;
                        w_cnt_nxt   = c_cnt_one;
                        w_state_nxt = c_first_state;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_st_idle;
                    end
                end else if (ser_valid) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_shreg       <= '0;
            r_err_resync  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err_resync  <= w_resync_nxt;
            r_err_timeout <= w_timeout_nxt;
            r_err_overrun <= w_overrun_nxt;
            if (w_load) begin
                r_shreg <= w_shifted;
            end
        end
    end

    assign out_valid   = (r_state == c_st_full);
    assign out_bits    = r_shreg;
    assign err_resync  = r_err_resync;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nibble_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_nibble_deserializer
// Purpose : Self-checking bench for nibble_deserializer. Drives an MSB-first
//           and an LSB-first instance from the same serial stream and compares
//           both against a frame-level reference model every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nibble_deserializer;

    localparam int c_width   = 4;
    localparam int c_timeout = 8;

    logic clk;
    logic rst_n;
    logic ser_valid, ser_data, frame_start, out_ready;

    logic                 v_m, rs_m, to_m, ov_m;
    logic                 v_l, rs_l, to_l, ov_l;
    logic [c_width-1:0]   b_m, b_l;

    nibble_deserializer #(.WIDTH(c_width), .MSB_FIRST(1'b1), .TIMEOUT(c_timeout)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_data(ser_data),
        .frame_start(frame_start), .out_valid(v_m), .out_ready(out_ready), .out_bits(b_m),
        .err_resync(rs_m), .err_timeout(to_m), .err_overrun(ov_m)
    );

    nibble_deserializer #(.WIDTH(c_width), .MSB_FIRST(1'b0), .TIMEOUT(c_timeout)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_data(ser_data),
        .frame_start(frame_start), .out_valid(v_l), .out_ready(out_ready), .out_bits(b_l),
        .err_resync(rs_l), .err_timeout(to_l), .err_overrun(ov_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit         m_full, m_inframe;
    bit         m_q[$];
    int         m_idle;
    logic [3:0] m_word_msb, m_word_lsb;
    bit         m_res, m_tmo, m_ovr;

    function automatic void m_reset();
        m_full = 0; m_inframe = 0; m_q.delete(); m_idle = 0;
        m_word_msb = '0; m_word_lsb = '0;
        m_res = 0; m_tmo = 0; m_ovr = 0;
    endfunction

    function automatic void m_complete();
        int wm, wl;
        wm = 0; wl = 0;
        for (int i = 0; i < c_width; i++) begin
            if (m_q[i]) begin
                wm += 1 << (c_width - 1 - i);
                wl += 1 << i;
            end
        end
        m_word_msb = wm[3:0];
        m_word_lsb = wl[3:0];
        m_full = 1; m_inframe = 0;
    endfunction

    function automatic void m_start(input bit b);
        m_q.delete(); m_q.push_back(b); m_idle = 0; m_inframe = 1;
        if (m_q.size() == c_width) m_complete();
    endfunction

    function automatic void m_step(input bit sv, input bit sd, input bit fs, input bit rdy);
        m_res = 0; m_tmo = 0; m_ovr = 0;
        if (m_full) begin
            if (rdy) begin
                m_full = 0;
                if (sv && fs) m_start(sd);
            end else if (sv) begin
                m_ovr = 1;
            end
        end else if (m_inframe) begin
            if (sv) begin
                if (fs) begin
                    m_res = 1;
                    m_start(sd);
                end else begin
                    m_q.push_back(sd); m_idle = 0;
                    if (m_q.size() == c_width) m_complete();
                end
            end else begin
                m_idle++;
                if (c_timeout > 0 && m_idle >= c_timeout) begin
                    m_inframe = 0; m_tmo = 1;
                end
            end
        end else if (sv && fs) begin
            m_start(sd);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    int         xfer_cnt, res_cnt, tmo_cnt, ovr_cnt;
    logic [3:0] xfer_words[$];

    task automatic compare_all();
        check("valid_msb", 32'(v_m), 32'(m_full));
        check("valid_lsb", 32'(v_l), 32'(m_full));
        if (m_full) begin
            check("bits_msb", 32'(b_m), 32'(m_word_msb));
            check("bits_lsb", 32'(b_l), 32'(m_word_lsb));
        end
        check("resync_msb",  32'(rs_m), 32'(m_res));
        check("resync_lsb",  32'(rs_l), 32'(m_res));
        check("timeout_msb", 32'(to_m), 32'(m_tmo));
        check("timeout_lsb", 32'(to_l), 32'(m_tmo));
        check("overrun_msb", 32'(ov_m), 32'(m_ovr));
        check("overrun_lsb", 32'(ov_l), 32'(m_ovr));
    endtask

    task automatic step(input logic sv, input logic sd, input logic fs, input logic rdy);
        ser_valid = sv; ser_data = sd; frame_start = fs; out_ready = rdy;
        if (v_m && rdy) begin
            xfer_cnt++;
            xfer_words.push_back(b_m);
        end
        @(posedge clk);
        m_step(sv, sd, fs, rdy);
        #1;
        compare_all();
        if (rs_m) res_cnt++;
        if (to_m) tmo_cnt++;
        if (ov_m) ovr_cnt++;
    endtask

    task automatic clear_counts();
        xfer_cnt = 0; res_cnt = 0; tmo_cnt = 0; ovr_cnt = 0;
        xfer_words.delete();
    endtask

    // Sends a framed nibble, first listed bit first.
    task automatic send_frame(input logic [3:0] bits, input logic rdy);
        for (int i = 3; i >= 0; i--)
            step(1'b1, bits[i], (i == 3), rdy);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'({v_m, v_l}), 32'd0);
        check({tag, "_bits"},  32'({b_m, b_l}), 32'd0);
        check({tag, "_errs"},  32'({rs_m, to_m, ov_m, rs_l, to_l, ov_l}), 32'd0);
    endtask

    function automatic int det_f(input logic [3:0] x);
        return ($countones(x) == 2 || $countones(x) == 3) ? 1 : 0;
    endfunction

    initial begin
        rst_n = 1'b0; ser_valid = 0; ser_data = 0; frame_start = 0; out_ready = 0;
        m_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic MSB-first frame, LSB-first companion
        send_frame(4'b1011, 1'b1);
        check("t1_bits_msb", 32'(b_m), 32'h0000000B);
        check("t1_bits_lsb", 32'(b_l), 32'h0000000D);
        check("t1_det_f", 32'(det_f(b_m)), 32'd1);
        clear_counts();
        step(0, 0, 0, 1);
        check("t1_xfers", 32'(xfer_cnt), 32'd1);

        // 2: back-to-back frames with no bubble
        clear_counts();
        send_frame(4'b1111, 1'b1);
        send_frame(4'b0001, 1'b1);
        step(0, 0, 0, 1);
        check("t2_xfers", 32'(xfer_cnt), 32'd2);
        check("t2_word0", 32'(xfer_words[0]), 32'h0000000F);
        check("t2_word1", 32'(xfer_words[1]), 32'h00000001);
        check("t2_errs", 32'(res_cnt + tmo_cnt + ovr_cnt), 32'd0);

        // 3: overrun while the word is held
        clear_counts();
        send_frame(4'b1011, 1'b0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        check("t3_overruns", 32'(ovr_cnt), 32'd2);
        check("t3_held_bits", 32'(b_m), 32'h0000000B);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t3_xfers", 32'(xfer_cnt), 32'd1);

        // 4: timeout after two bits, then a clean frame
        clear_counts();
        step(1, 1, 1, 1);
        step(1, 0, 0, 1);
        repeat (c_timeout) step(0, 0, 0, 1);
        check("t4_timeouts", 32'(tmo_cnt), 32'd1);
        check("t4_no_xfer", 32'(xfer_cnt), 32'd0);
        send_frame(4'b0110, 1'b1);
        check("t4_bits_msb", 32'(b_m), 32'h00000006);
        step(0, 0, 0, 1);

        // 5: resync mid-frame
        clear_counts();
        step(1, 1, 1, 1);
        step(1, 1, 0, 1);
        send_frame(4'b0001, 1'b1);
        check("t5_resyncs", 32'(res_cnt), 32'd1);
        check("t5_bits_msb", 32'(b_m), 32'h00000001);
        check("t5_det_f", 32'(det_f(b_m)), 32'd0);
        step(0, 0, 0, 1);

        // 6: asynchronous reset mid-frame and mid-word
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(4'b1100, 1'b1);
        check("t6_bits_msb", 32'(b_m), 32'h0000000C);
        check("t6_bits_lsb", 32'(b_l), 32'h00000003);
        step(0, 0, 0, 1);

        // Random traffic, model-checked every cycle
        for (int blk = 0; blk < 48; blk++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            for (int c = 0; c < 64; c++) begin
                logic sv, sd, fs, rdy;
                case (mode)
                    0:       sv = ($urandom_range(0, 99) < 80);
                    1:       sv = ($urandom_range(0, 99) < 15);
                    default: sv = ($urandom_range(0, 99) < 60);
                endcase
                sd = 1'($urandom);
                if (m_inframe) fs = ($urandom_range(0, 99) < 8);
                else           fs = ($urandom_range(0, 99) < 80);
                rdy = (mode == 2) ? ($urandom_range(0, 99) < 25)
                                  : ($urandom_range(0, 99) < 75);
                step(sv, sd, fs, rdy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
